udp_fifo_tx_scheduler: RTL and testbench

- Sequences packet transmission from the read side of the sample FIFO (16-bit words, first-word-fall-through) into the UDP/GMII transmitter (8-bit payload, `payload_req` driven).
- Launches a packet only when a full payload is buffered and serialises each word high byte first.
- Enforces an inter-packet gap, detects a stalled transmitter, and keeps packet and error status.

---
 rtl/udp_fifo_tx_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_udp_fifo_tx_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_fifo_tx_scheduler.sv
// udp_fifo_tx_scheduler
// Moves packets from the read side of the sample FIFO (16-bit words, first-
// word-fall-through) into the UDP/GMII transmitter, one byte per payload_req,
// high byte first. A packet is launched only once a whole payload is buffered.
// An inter-packet gap follows every frame, a stall timer aborts a frame whose
// tx_done never arrives, and sticky status flags record underrun, overrun and
// timeout.
//
// Byte handshake with the transmitter: payload_req is the request strobe and
// is honoured in the cycle it is seen. payload_dat is combinational from
// payload_req and the FIFO head word, so it is valid in that same cycle; there
// is no back-pressure toward the transmitter. On the FIFO side, fifo_rd_en is
// the pop strobe: it is only raised while !fifo_empty, and it coincides with
// the low byte of the head word being served.
module udp_fifo_tx_scheduler #(
  parameter int PKT_BYTES      = 800,
  parameter int IFG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int LEVEL_W        = 10
) (
  input  logic               clk125M,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear_err,
  input  logic [LEVEL_W-1:0] fifo_rd_count,
  input  logic               fifo_empty,
  input  logic [15:0]        fifo_dout,
  output logic               fifo_rd_en,
  output logic               tx_en_pulse,
  input  logic               payload_req,
  output logic [7:0]         payload_dat,
  input  logic               tx_done,
  output logic               busy,
  output logic [31:0]        pkt_cnt,
  output logic               underrun,
  output logic               overrun,
  output logic               timeout_err,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Counter widths: byte counter spans 0..PKT_BYTES, gap counter 0..IFG-1,
  // stall timer 0..TIMEOUT-1.
  localparam int CNT_W = $clog2(PKT_BYTES + 1);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(PKT_BYTES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST     = GAP_W'(IFG_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST     = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LAUNCH_WORDS = LEVEL_W'(PKT_BYTES / 2);

  state_t           state;
  logic             lane;       // 0: next byte is fifo_dout[15:8], 1: [7:0]
  logic [CNT_W-1:0] byte_cnt;   // bytes served in the current packet
  logic [GAP_W-1:0] gap_cnt;    // cycles spent in GAP
  logic [TMR_W-1:0] timer;      // cycles since the frame left ARM

  logic byte_due;
  logic timer_active;
  logic timer_expire;
  logic underrun_set;
  logic overrun_set;
  logic timeout_set;

  // A byte is owed to the transmitter only while streaming.
  assign byte_due     = (state == STREAM) && payload_req;
  assign timer_active = (state == STREAM) || (state == WAIT_DONE);
  assign timer_expire = timer_active && (timer == TMR_LAST);

  // Status set conditions. A tx_done in the expiry cycle counts as a clean
  // finish, so it suppresses the timeout.
  assign underrun_set = byte_due && fifo_empty;
  assign overrun_set  = (state == WAIT_DONE) && payload_req;
  assign timeout_set  = timer_expire && !tx_done;

  assign state_dbg = state;

  // Byte lane select and FIFO pop; both follow payload_req within the cycle.
  always_comb begin
    payload_dat = 8'h00;
    fifo_rd_en  = 1'b0;
    if (byte_due && !fifo_empty) begin
      payload_dat = lane ? fifo_dout[7:0] : fifo_dout[15:8];
      fifo_rd_en  = lane;
    end
  end

  // Packet sequencer: launch, stream, wait for end of frame, inter-packet gap.
  always_ff @(posedge clk125M or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_en_pulse <= 1'b0;
      busy        <= 1'b0;
      lane        <= 1'b0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      timer       <= '0;
      pkt_cnt     <= 32'd0;
    end else begin
      tx_en_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // enable only matters here; a packet in flight always completes.
          if (enable && (fifo_rd_count >= LAUNCH_WORDS)) begin
            state       <= ARM;
            tx_en_pulse <= 1'b1;
            busy        <= 1'b1;
            lane        <= 1'b0;
            byte_cnt    <= '0;
          end
        end

        ARM: begin
          state <= STREAM;
          timer <= '0;
        end

        STREAM: begin
          timer <= timer + TMR_W'(1);
          if (tx_done) begin
            // Early end of frame: count it, whatever was popped is gone.
            pkt_cnt <= pkt_cnt + 32'd1;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (timer_expire) begin
            lane     <= 1'b0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            state    <= GAP;
          end else if (payload_req) begin
            // Lane and count advance even on an empty FIFO so the frame
            // keeps its length.
            lane     <= ~lane;
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (byte_cnt == CNT_LAST) begin
              state <= WAIT_DONE;
            end
          end
        end

        WAIT_DONE: begin
          timer <= timer + TMR_W'(1);
          if (tx_done) begin
            pkt_cnt <= pkt_cnt + 32'd1;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (timer_expire) begin
            lane     <= 1'b0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as clear_err wins.
  always_ff @(posedge clk125M or negedge reset_n) begin
    if (!reset_n) begin
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (underrun_set) begin
        underrun <= 1'b1;
      end else if (clear_err) begin
        underrun <= 1'b0;
      end

      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end

      if (timeout_set) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_fifo_tx_scheduler.sv
// Bench for udp_fifo_tx_scheduler with PKT_BYTES=8, IFG_CYCLES=4,
// TIMEOUT_CYCLES=64. Inputs change 1 ns after the rising edge, outputs are
// sampled on the falling edge. A queue models the FWFT FIFO; its head shows
// 16'hDEAD while empty so that data leaking through an empty FIFO is visible.
`timescale 1ns/1ps
module tb_udp_fifo_tx_scheduler;

  localparam int PKT_BYTES      = 8;
  localparam int IFG_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int LEVEL_W        = 10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  // ---------------- clock / reset / DUT ----------------
  logic               clk125M = 1'b0;
  logic               reset_n = 1'b1;
  logic               enable = 1'b0;
  logic               clear_err = 1'b0;
  logic [LEVEL_W-1:0] fifo_rd_count;
  logic               fifo_empty;
  logic [15:0]        fifo_dout;
  logic               fifo_rd_en;
  logic               tx_en_pulse;
  logic               payload_req = 1'b0;
  logic [7:0]         payload_dat;
  logic               tx_done = 1'b0;
  logic               busy;
  logic [31:0]        pkt_cnt;
  logic               underrun;
  logic               overrun;
  logic               timeout_err;
  logic [2:0]         state_dbg;

  always #4 clk125M = ~clk125M;

  udp_fifo_tx_scheduler #(
    .PKT_BYTES      (PKT_BYTES),
    .IFG_CYCLES     (IFG_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .LEVEL_W        (LEVEL_W)
  ) dut (
    .clk125M       (clk125M),
    .reset_n       (reset_n),
    .enable        (enable),
    .clear_err     (clear_err),
    .fifo_rd_count (fifo_rd_count),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout),
    .fifo_rd_en    (fifo_rd_en),
    .tx_en_pulse   (tx_en_pulse),
    .payload_req   (payload_req),
    .payload_dat   (payload_dat),
    .tx_done       (tx_done),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt),
    .underrun      (underrun),
    .overrun       (overrun),
    .timeout_err   (timeout_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- FIFO model and sampled outputs ----------------
  logic [15:0] fifo_q[$];
  int          count_ovr = -1;   // >= 0 forces fifo_rd_count
  int          pops = 0;

  logic [7:0]  s_dat;
  logic        s_rd;
  logic        s_txen;
  logic        s_busy;
  logic [2:0]  s_state;
  logic [2:0]  s_flags;          // {underrun, overrun, timeout_err}
  logic [31:0] s_pkt;

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        req;
    logic        done;
    logic [7:0]  dat;
    logic        rd;
    logic        txen;
    logic        bsy;
    logic [2:0]  st;
    logic [31:0] pkt;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty    = (fifo_q.size() == 0);
    fifo_dout     = fifo_empty ? 16'hDEAD : fifo_q[0];
    fifo_rd_count = (count_ovr >= 0) ? LEVEL_W'(count_ovr) : LEVEL_W'(fifo_q.size());
  endtask

  // One clock: sample on the falling edge, then apply the pop after the rise.
  task automatic tick();
    logic [15:0] tmp;
    @(negedge clk125M);
    s_dat   = payload_dat;
    s_rd    = fifo_rd_en;
    s_txen  = tx_en_pulse;
    s_busy  = busy;
    s_state = state_dbg;
    s_pkt   = pkt_cnt;
    s_flags = {underrun, overrun, timeout_err};
    @(posedge clk125M);
    #1;
    if (s_rd) begin
      pops++;
      if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
    end
    refresh_fifo();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_arm(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_txen && n < 20);
    chk($sformatf("%s arm", tag), {31'd0, s_txen}, 32'd1);
    chk($sformatf("%s arm_state", tag), {29'd0, s_state}, {29'd0, S_ARM});
  endtask

  task automatic serve(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      payload_req = 1'b1;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("%s byte%0d", tag, i), {24'd0, s_dat}, {24'd0, e});
    end
    payload_req = 1'b0;
  endtask

  task automatic finish_pkt(input string tag, output logic [2:0] flags_at_done);
    payload_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    flags_at_done = s_flags;
    chk($sformatf("%s done_state", tag), {29'd0, s_state}, {29'd0, S_WAIT});
    repeat (IFG_CYCLES + 1) tick();
    chk($sformatf("%s idle_after_gap", tag), {29'd0, s_state}, {29'd0, S_IDLE});
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  function automatic void add(input logic [2:0] st, input logic req, input logic done,
                              input logic [7:0] dat, input logic rd, input logic txen,
                              input logic bsy, input logic [31:0] pkt, input logic [2:0] flags);
    vec_t v;
    v.st = st; v.req = req; v.done = done; v.dat = dat; v.rd = rd;
    v.txen = txen; v.bsy = bsy; v.pkt = pkt; v.flags = flags;
    vecs.push_back(v);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] fl;
    int seen;

    refresh_fifo();

    // Reset values.
    #1 reset_n = 1'b0;
    #20;
    chk("rst payload_dat", {24'd0, payload_dat}, 32'd0);
    chk("rst fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst tx_en_pulse", {31'd0, tx_en_pulse}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst pkt_cnt", pkt_cnt, 32'd0);
    chk("rst flags", {29'd0, underrun, overrun, timeout_err}, 32'd0);
    chk("rst state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    @(posedge clk125M);
    #1 reset_n = 1'b1;

    // Test 1: two back-to-back packets, table driven.
    fifo_q = '{16'h1234, 16'h0001, 16'h5678, 16'hAABB,
               16'hCAFE, 16'hBEEF, 16'h0102, 16'h0304};
    refresh_fifo();
    enable = 1'b1;
    //  state     req done dat    rd txen busy pkt  flags
    add(S_IDLE,   0,  0,   8'h00, 0, 0,   0,   0,   3'b000);
    add(S_ARM,    0,  0,   8'h00, 0, 1,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'h12, 0, 0,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'h34, 1, 0,   1,   0,   3'b000);
    add(S_STREAM, 0,  0,   8'h00, 0, 0,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'h00, 0, 0,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'h01, 1, 0,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'h56, 0, 0,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'h78, 1, 0,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'hAA, 0, 0,   1,   0,   3'b000);
    add(S_STREAM, 1,  0,   8'hBB, 1, 0,   1,   0,   3'b000);
    add(S_WAIT,   0,  1,   8'h00, 0, 0,   1,   0,   3'b000);
    add(S_GAP,    0,  0,   8'h00, 0, 0,   1,   1,   3'b000);
    add(S_GAP,    0,  0,   8'h00, 0, 0,   1,   1,   3'b000);
    add(S_GAP,    0,  0,   8'h00, 0, 0,   1,   1,   3'b000);
    add(S_GAP,    0,  0,   8'h00, 0, 0,   1,   1,   3'b000);
    add(S_IDLE,   0,  0,   8'h00, 0, 0,   0,   1,   3'b000);
    add(S_ARM,    0,  0,   8'h00, 0, 1,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'hCA, 0, 0,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'hFE, 1, 0,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'hBE, 0, 0,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'hEF, 1, 0,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'h01, 0, 0,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'h02, 1, 0,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'h03, 0, 0,   1,   1,   3'b000);
    add(S_STREAM, 1,  0,   8'h04, 1, 0,   1,   1,   3'b000);
    add(S_WAIT,   1,  0,   8'h00, 0, 0,   1,   1,   3'b000);
    add(S_WAIT,   0,  1,   8'h00, 0, 0,   1,   1,   3'b010);
    add(S_GAP,    0,  0,   8'h00, 0, 0,   1,   2,   3'b010);
    for (int i = 0; i < vecs.size(); i++) begin
      payload_req = vecs[i].req;
      tx_done     = vecs[i].done;
      tick();
      chk($sformatf("vec%0d state", i), {29'd0, s_state}, {29'd0, vecs[i].st});
      chk($sformatf("vec%0d dat", i), {24'd0, s_dat}, {24'd0, vecs[i].dat});
      chk($sformatf("vec%0d rd_en", i), {31'd0, s_rd}, {31'd0, vecs[i].rd});
      chk($sformatf("vec%0d tx_en", i), {31'd0, s_txen}, {31'd0, vecs[i].txen});
      chk($sformatf("vec%0d busy", i), {31'd0, s_busy}, {31'd0, vecs[i].bsy});
      chk($sformatf("vec%0d pkt_cnt", i), s_pkt, vecs[i].pkt);
      chk($sformatf("vec%0d flags", i), {29'd0, s_flags}, {29'd0, vecs[i].flags});
    end
    payload_req = 1'b0;
    tx_done = 1'b0;
    repeat (IFG_CYCLES) tick();
    chk("t1 idle_end", {29'd0, s_state}, {29'd0, S_IDLE});
    pulse_clear();
    tick();
    chk("t1 overrun_cleared", {29'd0, s_flags}, 32'd0);

    // Test 2: below threshold, then one more word launches next cycle.
    fifo_q = '{16'h1111, 16'h2222, 16'h3333};
    refresh_fifo();
    seen = 0;
    repeat (20) begin
      tick();
      if (s_txen || s_busy) seen++;
    end
    chk("t2 no_launch_below", seen, 0);
    fifo_q.push_back(16'h4444);
    refresh_fifo();
    tick();
    chk("t2 idle_at_raise", {29'd0, s_state}, {29'd0, S_IDLE});
    tick();
    chk("t2 arm_next", {29'd0, s_state}, {29'd0, S_ARM});
    chk("t2 tx_en", {31'd0, s_txen}, 32'd1);
    exp_q = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    pops = 0;
    serve(8, "t2");
    chk("t2 pops", pops, 4);
    finish_pkt("t2", fl);
    chk("t2 pkt_cnt", s_pkt, 32'd3);

    // Test 3: underrun after two words; clear_err loses to a same-cycle set.
    fifo_q = '{16'hA1B2, 16'hC3D4};
    count_ovr = 4;
    refresh_fifo();
    wait_arm("t3");
    count_ovr = -1;
    refresh_fifo();
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00};
    pops = 0;
    serve(7, "t3");
    payload_req = 1'b1;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    payload_req = 1'b0;
    chk("t3 byte7", {24'd0, s_dat}, 32'd0);
    chk("t3 no_pop_empty", {31'd0, s_rd}, 32'd0);
    finish_pkt("t3", fl);
    chk("t3 underrun_set_wins", {31'd0, fl[2]}, 32'd1);
    chk("t3 pops", pops, 2);
    chk("t3 pkt_cnt", s_pkt, 32'd4);
    pulse_clear();
    tick();
    chk("t3 underrun_cleared", {29'd0, s_flags}, 32'd0);

    // Test 4: timeout with tx_done withheld.
    fifo_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    refresh_fifo();
    wait_arm("t4");
    enable = 1'b0;
    exp_q = '{8'h01, 8'h02};
    serve(2, "t4");
    seen = 0;
    repeat (TIMEOUT_CYCLES - 3) begin
      tick();
      if (s_flags[0]) seen++;
    end
    tick();
    chk("t4 no_early_timeout", seen + {31'd0, s_flags[0]}, 0);
    chk("t4 stream_at_64", {29'd0, s_state}, {29'd0, S_STREAM});
    tick();
    chk("t4 timeout_err", {29'd0, s_flags}, 32'd1);
    chk("t4 gap", {29'd0, s_state}, {29'd0, S_GAP});
    chk("t4 pkt_unchanged", s_pkt, 32'd4);
    repeat (IFG_CYCLES - 1) tick();
    tick();
    chk("t4 idle", {29'd0, s_state}, {29'd0, S_IDLE});
    chk("t4 busy", {31'd0, s_busy}, 32'd0);
    pulse_clear();
    tick();
    chk("t4 timeout_cleared", {29'd0, s_flags}, 32'd0);

    // Test 5a: asynchronous reset in the middle of a packet.
    fifo_q = '{16'h89AB, 16'hCDEF, 16'h0011, 16'h2233};
    refresh_fifo();
    enable = 1'b1;
    wait_arm("t5");
    exp_q = '{8'h89, 8'hAB, 8'hCD};
    serve(3, "t5");
    payload_req = 1'b1;
    #1;
    chk("t5 pre_rst_dat", {24'd0, payload_dat}, 32'hEF);
    chk("t5 pre_rst_rd", {31'd0, fifo_rd_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5 rst_dat", {24'd0, payload_dat}, 32'd0);
    chk("t5 rst_rd", {31'd0, fifo_rd_en}, 32'd0);
    chk("t5 rst_busy", {31'd0, busy}, 32'd0);
    chk("t5 rst_pkt", pkt_cnt, 32'd0);
    chk("t5 rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    payload_req = 1'b0;
    @(posedge clk125M);
    #1 reset_n = 1'b1;

    // Test 5b: next packet starts on the high byte; enable dropped mid-packet.
    fifo_q = '{16'h5566, 16'h7788, 16'h99AA, 16'hBBCC};
    refresh_fifo();
    wait_arm("t5b");
    exp_q = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    serve(2, "t5b");
    enable = 1'b0;
    serve(6, "t5b");
    finish_pkt("t5b", fl);
    chk("t5b pkt_cnt", s_pkt, 32'd1);
    fifo_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    refresh_fifo();
    seen = 0;
    repeat (12) begin
      tick();
      if (s_txen || s_busy) seen++;
    end
    chk("t5b no_relaunch", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
